// File: rtl/fsl_traffic_client.sv
// FSL traffic endpoint: generates framed incrementing-sequence packets on the
// master link and checks the same sequence/framing on the slave link.
//
// TX state | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no traffic; waits for enable
// SEND     | one word offered per cycle, stalled by fsl_m_full
// GAP      | GAP idle cycles after a packet (down-counter to zero)
module fsl_traffic_client #(
  parameter int FSL_D_WIDTH = 32,
  parameter int PKT_LEN     = 70,
  parameter int GAP         = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   gclk,
  input  logic                   reset_l,
  input  logic                   enable,
  input  logic                   clear_stats,
  input  logic                   fsl_m_full,
  output logic                   fsl_m_write,
  output logic [FSL_D_WIDTH-1:0] fsl_m_data,
  output logic                   fsl_m_control,
  input  logic                   fsl_s_exists,
  input  logic                   fsl_s_control,
  input  logic [FSL_D_WIDTH-1:0] fsl_s_data,
  output logic                   fsl_s_read,
  output logic [7:0]             data_out,
  output logic [CNT_WIDTH-1:0]   pkt_sent_cnt,
  output logic [CNT_WIDTH-1:0]   pkt_rcvd_cnt,
  output logic [ERR_WIDTH-1:0]   err_cnt,
  output logic                   err_flag
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
  // When GAP is 0 the GAP state is never entered, so the load value is unused.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  tx_state_e              state_q, state_d;
  logic [FSL_D_WIDTH-1:0] tx_seq_q;
  logic [IDX_W-1:0]       tx_idx_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [FSL_D_WIDTH-1:0] rx_seq_q;
  logic [IDX_W-1:0]       rx_idx_q;
  logic [7:0]             data_out_q;
  logic [CNT_WIDTH-1:0]   pkt_sent_q;
  logic [CNT_WIDTH-1:0]   pkt_rcvd_q;
  logic [ERR_WIDTH-1:0]   err_cnt_q;
  logic                   err_flag_q;

  logic tx_wr;
  logic tx_last;
  logic tx_pkt_done;
  logic rx_rd;
  logic rx_exp_ctrl;
  logic rx_err;

  assign tx_last     = (tx_idx_q == IDX_LAST);
  assign tx_pkt_done = tx_wr & tx_last;

  // TX state register
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // TX next-state: a started packet always runs to its control word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_SEND;
      ST_SEND: begin
        if (tx_pkt_done) begin
          if (GAP == 0) state_d = enable ? ST_SEND : ST_IDLE;
          else          state_d = ST_GAP;
        end
      end
      ST_GAP:  if (gap_cnt_q == '0) state_d = enable ? ST_SEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // TX outputs: write strobe follows full combinationally, data/control from registers
  always_comb begin
    fsl_m_write   = (state_q == ST_SEND) & ~fsl_m_full;
    fsl_m_control = (state_q == ST_SEND) & tx_last;
    fsl_m_data    = tx_seq_q;
    tx_wr         = fsl_m_write;
  end

  // TX sequence, word index and gap timer
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      tx_seq_q  <= '0;
      tx_idx_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (tx_wr) begin
        tx_seq_q <= tx_seq_q + 1'b1;
        tx_idx_q <= tx_last ? '0 : tx_idx_q + 1'b1;
      end
      if (tx_pkt_done)
        gap_cnt_q <= GAP_LOAD;
      else if (state_q == ST_GAP && gap_cnt_q != '0)
        gap_cnt_q <= gap_cnt_q - 1'b1;
    end
  end

  // RX: every available word is consumed and compared against the expected stream
  assign rx_rd       = fsl_s_exists;
  assign fsl_s_read  = fsl_s_exists;
  assign rx_exp_ctrl = (rx_idx_q == IDX_LAST);
  assign rx_err      = rx_rd & ((fsl_s_data != rx_seq_q) | (fsl_s_control != rx_exp_ctrl));

  // RX expected sequence resyncs to the received word; framing index wraps
  // at the packet boundary even if the control bit was missing
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      rx_seq_q   <= '0;
      rx_idx_q   <= '0;
      data_out_q <= '0;
    end else if (rx_rd) begin
      rx_seq_q   <= fsl_s_data + 1'b1;
      rx_idx_q   <= (fsl_s_control || rx_exp_ctrl) ? '0 : rx_idx_q + 1'b1;
      data_out_q <= {1'b1, fsl_s_control, fsl_s_data[5:0]};
    end
  end

  // Statistics: clear wins over any same-cycle increment
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      pkt_sent_q <= '0;
      pkt_rcvd_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (clear_stats) begin
      pkt_sent_q <= '0;
      pkt_rcvd_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      if (tx_pkt_done)                pkt_sent_q <= pkt_sent_q + 1'b1;
      if (rx_rd && fsl_s_control)     pkt_rcvd_q <= pkt_rcvd_q + 1'b1;
      if (rx_err && err_cnt_q != '1)  err_cnt_q  <= err_cnt_q + 1'b1;
      if (rx_err)                     err_flag_q <= 1'b1;
    end
  end

  assign data_out     = data_out_q;
  assign pkt_sent_cnt = pkt_sent_q;
  assign pkt_rcvd_cnt = pkt_rcvd_q;
  assign err_cnt      = err_cnt_q;
  assign err_flag     = err_flag_q;

endmodule

// File: tb/tb_fsl_traffic_client.sv
// Bench for fsl_traffic_client: instance A (32-bit, PKT_LEN=4, GAP=2) looped
// back through a 16-deep FIFO, instance B (8-bit, PKT_LEN=1, GAP=0) looped
// back directly; both can have their slave side driven by hand instead.
module tb_fsl_traffic_client;

  logic gclk;
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        rst_a = 1'b0, en_a = 1'b0, clr_a = 1'b0, force_full = 1'b0;
  logic        inj_a = 1'b0, inj_ex_a = 1'b0, inj_c_a = 1'b0;
  logic [31:0] inj_d_a = '0;
  logic        full_a, m_write_a, m_ctrl_a, s_exists_a, s_ctrl_a, s_read_a, eflag_a;
  logic [31:0] m_data_a, s_data_a;
  logic [7:0]  dout_a, errc_a;
  logic [15:0] sent_a, rcvd_a;

  logic [32:0] f_mem [16];
  logic [3:0]  f_wp, f_rp;
  logic [4:0]  f_cnt;

  assign full_a     = (f_cnt == 5'd16) | force_full;
  assign s_exists_a = inj_a ? inj_ex_a : (f_cnt != 5'd0);
  assign s_ctrl_a   = inj_a ? inj_c_a  : f_mem[f_rp][32];
  assign s_data_a   = inj_a ? inj_d_a  : f_mem[f_rp][31:0];

  always @(posedge gclk or negedge rst_a) begin
    if (!rst_a) begin
      f_wp <= '0; f_rp <= '0; f_cnt <= '0;
    end else begin
      if (m_write_a) begin
        f_mem[f_wp] <= {m_ctrl_a, m_data_a};
        f_wp <= f_wp + 4'd1;
      end
      if (!inj_a && s_read_a) f_rp <= f_rp + 4'd1;
      f_cnt <= f_cnt + 5'(m_write_a) - 5'(!inj_a && s_read_a);
    end
  end

  fsl_traffic_client #(.FSL_D_WIDTH(32), .PKT_LEN(4), .GAP(2), .CNT_WIDTH(16), .ERR_WIDTH(8)) u_a (
    .gclk(gclk), .reset_l(rst_a), .enable(en_a), .clear_stats(clr_a),
    .fsl_m_full(full_a), .fsl_m_write(m_write_a), .fsl_m_data(m_data_a), .fsl_m_control(m_ctrl_a),
    .fsl_s_exists(s_exists_a), .fsl_s_control(s_ctrl_a), .fsl_s_data(s_data_a), .fsl_s_read(s_read_a),
    .data_out(dout_a), .pkt_sent_cnt(sent_a), .pkt_rcvd_cnt(rcvd_a), .err_cnt(errc_a), .err_flag(eflag_a)
  );

  // write log for instance A, sampled mid-cycle
  int          log_n = 0;
  logic [31:0] log_d [512];
  logic        log_c [512];
  int          log_cyc [512];
  always @(negedge gclk) begin
    if (m_write_a && log_n < 512) begin
      log_d[log_n]   = m_data_a;
      log_c[log_n]   = m_ctrl_a;
      log_cyc[log_n] = cyc;
      log_n          = log_n + 1;
    end
  end

  // ---------------- instance B ----------------
  logic       rst_b = 1'b0, en_b = 1'b0, clr_b = 1'b0;
  logic       inj_b = 1'b0, inj_ex_b = 1'b0, inj_c_b = 1'b0;
  logic [7:0] inj_d_b = '0;
  logic       m_write_b, m_ctrl_b, s_read_b, eflag_b;
  logic [7:0] m_data_b, dout_b, errc_b;
  logic [15:0] sent_b, rcvd_b;

  fsl_traffic_client #(.FSL_D_WIDTH(8), .PKT_LEN(1), .GAP(0), .CNT_WIDTH(16), .ERR_WIDTH(8)) u_b (
    .gclk(gclk), .reset_l(rst_b), .enable(en_b), .clear_stats(clr_b),
    .fsl_m_full(1'b0), .fsl_m_write(m_write_b), .fsl_m_data(m_data_b), .fsl_m_control(m_ctrl_b),
    .fsl_s_exists(inj_b ? inj_ex_b : m_write_b), .fsl_s_control(inj_b ? inj_c_b : m_ctrl_b),
    .fsl_s_data(inj_b ? inj_d_b : m_data_b), .fsl_s_read(s_read_b),
    .data_out(dout_b), .pkt_sent_cnt(sent_b), .pkt_rcvd_cnt(rcvd_b), .err_cnt(errc_b), .err_flag(eflag_b)
  );

  // instance B reference sequence: each word must be the next byte with control=1
  int         wcnt_b = 0;
  int         bad_b = 0;
  logic [7:0] exp_b = '0;
  always @(negedge gclk) begin
    if (!rst_b) exp_b = 8'd0;
    else if (m_write_b) begin
      wcnt_b = wcnt_b + 1;
      if (m_data_b !== exp_b || m_ctrl_b !== 1'b1) bad_b = bad_b + 1;
      exp_b = exp_b + 8'd1;
    end
  end

  // ---------------- helpers ----------------
  task automatic reset_a();
    rst_a = 1'b0;
    repeat (2) @(negedge gclk);
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    repeat (2) @(negedge gclk);
    rst_b = 1'b1;
  endtask

  task automatic wait_write_a(input logic [31:0] val, input string nm);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge gclk);
      if (m_write_a && m_data_a == val) ok = 1;
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s: timeout waiting for write of %0d", nm, val); end
  endtask

  task automatic drive_a(input logic [31:0] d, input logic c);
    inj_ex_a = 1'b1; inj_d_a = d; inj_c_a = c;
    @(negedge gclk);
    inj_ex_a = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] d, input logic c);
    inj_ex_b = 1'b1; inj_d_b = d; inj_c_b = c;
    @(negedge gclk);
    inj_ex_b = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge gclk);
    n_cmp++; if (m_write_a !== 1'b0) begin n_err++; $display("FAIL reset_m_write: got %0h want 0", m_write_a); end
    n_cmp++; if (m_data_a !== 32'd0) begin n_err++; $display("FAIL reset_m_data: got %0h want 0", m_data_a); end
    n_cmp++; if (m_ctrl_a !== 1'b0) begin n_err++; $display("FAIL reset_m_control: got %0h want 0", m_ctrl_a); end
    n_cmp++; if (s_read_a !== 1'b0) begin n_err++; $display("FAIL reset_s_read: got %0h want 0", s_read_a); end
    n_cmp++; if (dout_a !== 8'd0) begin n_err++; $display("FAIL reset_data_out: got %0h want 0", dout_a); end
    n_cmp++; if (sent_a !== 16'd0 || rcvd_a !== 16'd0) begin n_err++; $display("FAIL reset_pkt_cnts: got %0d/%0d want 0/0", sent_a, rcvd_a); end
    n_cmp++; if (errc_a !== 8'd0 || eflag_a !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0d/%0h want 0/0", errc_a, eflag_a); end
    n_cmp++; if (m_write_b !== 1'b0 || m_data_b !== 8'd0) begin n_err++; $display("FAIL reset_b_tx: got %0h/%0h want 0/0", m_write_b, m_data_b); end
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_loopback();
    int base, n, bad;
    base = log_n;
    en_a = 1'b1;
    repeat (40) @(negedge gclk);
    en_a = 1'b0;
    repeat (30) @(negedge gclk);
    n = log_n - base;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (log_d[base+i] !== 32'(i) || log_c[base+i] !== ((i % 4) == 3)) bad++;
    n_cmp++; if (n < 8) begin n_err++; $display("FAIL loop_word_count: got %0d want >=8", n); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL loop_sequence: got %0d bad words want 0", bad); end
    n_cmp++; if (n >= 5 && log_cyc[base+4] - log_cyc[base+3] != 3) begin n_err++; $display("FAIL loop_gap: got %0d cycles want 3", log_cyc[base+4] - log_cyc[base+3]); end
    n_cmp++; if (n >= 4 && log_cyc[base+3] - log_cyc[base] != 3) begin n_err++; $display("FAIL loop_b2b: got %0d cycles want 3", log_cyc[base+3] - log_cyc[base]); end
    n_cmp++; if (32'(sent_a) * 4 != n) begin n_err++; $display("FAIL loop_sent: got %0d want %0d", sent_a, n / 4); end
    n_cmp++; if (rcvd_a !== sent_a) begin n_err++; $display("FAIL loop_rcvd: got %0d want %0d", rcvd_a, sent_a); end
    n_cmp++; if (errc_a !== 8'd0 || eflag_a !== 1'b0) begin n_err++; $display("FAIL loop_err: got %0d/%0h want 0/0", errc_a, eflag_a); end
  endtask

  task automatic test_backpressure();
    int base, n, bad;
    reset_a();
    base = log_n;
    en_a = 1'b1;
    wait_write_a(32'd2, "bp_wait");
    @(posedge gclk); #1 force_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge gclk);
      n_cmp++;
      if (m_write_a !== 1'b0 || m_data_a !== 32'd3 || m_ctrl_a !== 1'b1) begin
        n_err++; $display("FAIL bp_hold_%0d: got wr=%0h d=%0d c=%0h want 0/3/1", k, m_write_a, m_data_a, m_ctrl_a);
      end
    end
    @(posedge gclk); #1 force_full = 1'b0;
    repeat (20) @(negedge gclk);
    en_a = 1'b0;
    repeat (20) @(negedge gclk);
    n = log_n - base;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (log_d[base+i] !== 32'(i) || log_c[base+i] !== ((i % 4) == 3)) bad++;
    n_cmp++; if (n < 8 || bad != 0) begin n_err++; $display("FAIL bp_resume: got %0d words %0d bad want >=8 words 0 bad", n, bad); end
    n_cmp++; if (rcvd_a !== sent_a || errc_a !== 8'd0) begin n_err++; $display("FAIL bp_rx: got rcvd=%0d err=%0d want %0d/0", rcvd_a, errc_a, sent_a); end
  endtask

  task automatic test_drop_enable();
    int base, n, bad;
    reset_a();
    base = log_n;
    en_a = 1'b1;
    wait_write_a(32'd1, "drop_wait");
    en_a = 1'b0;
    repeat (20) @(negedge gclk);
    n = log_n - base;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (log_d[base+i] !== 32'(i) || log_c[base+i] !== (i == 3)) bad++;
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL drop_count: got %0d words want 4", n); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL drop_words: got %0d bad want 0", bad); end
    n_cmp++; if (sent_a !== 16'd1 || m_write_a !== 1'b0) begin n_err++; $display("FAIL drop_idle: got sent=%0d wr=%0h want 1/0", sent_a, m_write_a); end
  endtask

  task automatic test_async_reset();
    int base;
    reset_a();
    en_a = 1'b1;
    wait_write_a(32'd6, "ar_wait");
    #2 rst_a = 1'b0;
    #1;
    n_cmp++; if (m_write_a !== 1'b0 || m_data_a !== 32'd0 || m_ctrl_a !== 1'b0) begin n_err++; $display("FAIL ar_tx: got %0h/%0h/%0h want 0/0/0", m_write_a, m_data_a, m_ctrl_a); end
    n_cmp++; if (sent_a !== 16'd0 || rcvd_a !== 16'd0 || dout_a !== 8'd0) begin n_err++; $display("FAIL ar_stats: got %0d/%0d/%0h want 0/0/0", sent_a, rcvd_a, dout_a); end
    @(negedge gclk);
    base = log_n;
    rst_a = 1'b1;
    repeat (5) @(negedge gclk);
    n_cmp++; if (log_n <= base || log_d[base] !== 32'd0) begin n_err++; $display("FAIL ar_first_word: got n=%0d d=%0h want word 0", log_n - base, log_d[base]); end
    en_a = 1'b0;
    repeat (20) @(negedge gclk);
  endtask

  task automatic test_inject();
    reset_a();
    inj_a = 1'b1;
    inj_ex_a = 1'b1; inj_d_a = 32'd0; inj_c_a = 1'b0;
    #1;
    n_cmp++; if (s_read_a !== 1'b1) begin n_err++; $display("FAIL inj_s_read: got %0h want 1", s_read_a); end
    @(negedge gclk); inj_ex_a = 1'b0;
    n_cmp++; if (dout_a !== 8'h80 || errc_a !== 8'd0) begin n_err++; $display("FAIL inj_w0: got dout=%0h err=%0d want 80/0", dout_a, errc_a); end
    drive_a(32'd1, 1'b0);
    n_cmp++; if (errc_a !== 8'd0 || eflag_a !== 1'b0) begin n_err++; $display("FAIL inj_w1: got %0d/%0h want 0/0", errc_a, eflag_a); end
    drive_a(32'd7, 1'b0);
    n_cmp++; if (errc_a !== 8'd1 || eflag_a !== 1'b1) begin n_err++; $display("FAIL inj_w7: got %0d/%0h want 1/1", errc_a, eflag_a); end
    drive_a(32'd8, 1'b1);
    n_cmp++; if (errc_a !== 8'd1 || rcvd_a !== 16'd1 || dout_a !== 8'hC8) begin n_err++; $display("FAIL inj_w8: got err=%0d rcvd=%0d dout=%0h want 1/1/c8", errc_a, rcvd_a, dout_a); end
  endtask

  task automatic test_clear();
    clr_a = 1'b1;
    drive_a(32'd100, 1'b1);
    clr_a = 1'b0;
    n_cmp++; if (errc_a !== 8'd0 || eflag_a !== 1'b0 || rcvd_a !== 16'd0) begin n_err++; $display("FAIL clr_priority: got %0d/%0h/%0d want 0/0/0", errc_a, eflag_a, rcvd_a); end
    drive_a(32'd101, 1'b0);
    n_cmp++; if (errc_a !== 8'd0 || dout_a !== 8'hA5) begin n_err++; $display("FAIL clr_resync: got err=%0d dout=%0h want 0/a5", errc_a, dout_a); end
    inj_a = 1'b0;
  endtask

  task automatic test_wrap();
    int base_w, base_bad, n;
    bit ok = 0;
    reset_b();
    base_w = wcnt_b; base_bad = bad_b;
    en_b = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge gclk);
      if (wcnt_b - base_w >= 300) ok = 1;
    end
    en_b = 1'b0;
    repeat (5) @(negedge gclk);
    n = wcnt_b - base_w;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got %0d words want 300", n); end
    n_cmp++; if (bad_b - base_bad != 0) begin n_err++; $display("FAIL wrap_seq: got %0d bad want 0", bad_b - base_bad); end
    n_cmp++; if (errc_b !== 8'd0 || eflag_b !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %0d/%0h want 0/0", errc_b, eflag_b); end
    n_cmp++; if (32'(sent_b) != n || rcvd_b !== sent_b) begin n_err++; $display("FAIL wrap_cnts: got %0d/%0d want %0d", sent_b, rcvd_b, n); end
    n_cmp++; if (m_data_b !== 8'(n)) begin n_err++; $display("FAIL wrap_seq_next: got %0h want %0h", m_data_b, 8'(n)); end
  endtask

  task automatic test_saturate();
    reset_b();
    inj_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_b(8'(i), 1'b0);
      if (i == 253) begin
        n_cmp++; if (errc_b !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", errc_b); end
      end
      if (i == 254) begin
        n_cmp++; if (errc_b !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", errc_b); end
      end
    end
    n_cmp++; if (errc_b !== 8'd255 || eflag_b !== 1'b1 || rcvd_b !== 16'd0) begin n_err++; $display("FAIL sat_end: got %0d/%0h/%0d want 255/1/0", errc_b, eflag_b, rcvd_b); end
    inj_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_backpressure();
    test_drop_enable();
    test_async_reset();
    test_inject();
    test_clear();
    test_wrap();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
